// File: rtl/aes_key_sched_ctrl_if.sv
// Handshake bundle between the AES key-schedule sequencer and its neighbours:
// start/busy/done toward the top-level control FSM, kg_* toward the key-gen
// datapath, rk_* toward the cipher core consuming round keys.
interface aes_key_sched_ctrl_if;
   logic       start_i;
   logic       busy_o;
   logic       done_o;
   logic       kg_en_o;
   logic       kg_next_rnd_o;
   logic       kg_gen_key_o;
   logic [7:0] kg_rcon_o;
   logic       rk_valid_o;
   logic       rk_ready_i;
   logic [3:0] rk_idx_o;

   // Sequencer side
   modport master (
      input  start_i, rk_ready_i,
      output busy_o, done_o, kg_en_o, kg_next_rnd_o, kg_gen_key_o, kg_rcon_o,
             rk_valid_o, rk_idx_o
   );

   // Environment side (control FSM, datapath, key consumer)
   modport slave (
      output start_i, rk_ready_i,
      input  busy_o, done_o, kg_en_o, kg_next_rnd_o, kg_gen_key_o, kg_rcon_o,
             rk_valid_o, rk_idx_o
   );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-expansion sequencer. Steps the key-gen datapath through ROUNDS
// rounds (FETCH -> CALC -> PRESENT per round) and hands each round key to the
// consumer over valid/ready, freezing the datapath while the consumer stalls.
// Optional feature macro: AES_KS_ABORT_EN adds the abort_i cancel input.
module aes_key_sched_ctrl #(
   parameter int ROUNDS   = 10,
   parameter int PIPE_LAT = 2
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef AES_KS_ABORT_EN
   input  logic                  abort_i,
`endif
   aes_key_sched_ctrl_if.master  bus
);

   localparam int STG_W = (PIPE_LAT > 2) ? $clog2(PIPE_LAT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_CALC,
      S_PRESENT,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       round_q, round_d;
   logic [7:0]       rcon_q,  rcon_d;
   logic [STG_W-1:0] stage_q, stage_d;
   logic             abort_hit;

   // GF(2^8) doubling used to advance the round constant
   function automatic logic [7:0] xtime(input logic [7:0] r);
      return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
   endfunction

`ifdef AES_KS_ABORT_EN
   assign abort_hit = abort_i && (state_q != S_IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   // State, round counter, round constant and CALC stage counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         round_q <= 4'd0;
         rcon_q  <= 8'h01;
         stage_q <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         rcon_q  <= rcon_d;
         stage_q <= stage_d;
      end
   end

   // Next-state logic and Moore outputs decoded from the current state
   always_comb begin
      state_d           = state_q;
      round_d           = round_q;
      rcon_d            = rcon_q;
      stage_d           = stage_q;
      bus.busy_o        = 1'b0;
      bus.done_o        = 1'b0;
      bus.kg_en_o       = 1'b0;
      bus.kg_next_rnd_o = 1'b0;
      bus.kg_gen_key_o  = 1'b0;
      bus.kg_rcon_o     = 8'h00;
      bus.rk_valid_o    = 1'b0;
      bus.rk_idx_o      = 4'd0;

      case (state_q)
         S_IDLE: begin
            if (bus.start_i) begin
               state_d = S_FETCH;
               round_d = 4'd1;
               rcon_d  = 8'h01;
            end
         end
         S_FETCH: begin
            // Round 1 loads the cipher key; later rounds feed back key_o
            bus.busy_o        = 1'b1;
            bus.kg_en_o       = 1'b1;
            bus.kg_next_rnd_o = (round_q > 4'd1);
            stage_d           = '0;
            state_d           = S_CALC;
         end
         S_CALC: begin
            bus.busy_o       = 1'b1;
            bus.kg_en_o      = 1'b1;
            bus.kg_gen_key_o = 1'b1;
            bus.kg_rcon_o    = rcon_q;
            if (stage_q == STG_W'(PIPE_LAT - 2)) begin
               state_d = S_PRESENT;
            end else begin
               stage_d = stage_q + 1'b1;
            end
         end
         S_PRESENT: begin
            // Datapath stays disabled so key_o holds while the consumer stalls
            bus.busy_o     = 1'b1;
            bus.rk_valid_o = 1'b1;
            bus.rk_idx_o   = round_q;
            if (bus.rk_ready_i) begin
               if (round_q == 4'(ROUNDS)) begin
                  state_d = S_DONE;
               end else begin
                  round_d = round_q + 4'd1;
                  rcon_d  = xtime(rcon_q);
                  state_d = S_FETCH;
               end
            end
         end
         S_DONE: begin
            // start_i is deliberately not looked at here
            bus.done_o = 1'b1;
            state_d    = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Cancel wins over everything, including a same-cycle key transfer
      if (abort_hit) begin
         state_d = S_IDLE;
      end
   end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for the AES key-schedule sequencer: per-round expectations
// come from a table of {round index, round constant} records; multi-cycle
// corners (stall, stray start, reset, abort) are hand-written sequences.
module tb_aes_key_sched_ctrl;

   logic clk;
   logic rst;
`ifdef AES_KS_ABORT_EN
   logic abort_i;
`endif
   int   n_tests;
   int   n_fail;

   aes_key_sched_ctrl_if bus ();

   aes_key_sched_ctrl #(
      .ROUNDS   (10),
      .PIPE_LAT (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
`ifdef AES_KS_ABORT_EN
      .abort_i (abort_i),
`endif
      .bus     (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] idx;
      logic [7:0] rcon;
   } rk_vec_t;

   rk_vec_t vec [10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " busy"},     32'(bus.busy_o), 0);
      check({tag, " done"},     32'(bus.done_o), 0);
      check({tag, " en"},       32'(bus.kg_en_o), 0);
      check({tag, " next_rnd"}, 32'(bus.kg_next_rnd_o), 0);
      check({tag, " gen_key"},  32'(bus.kg_gen_key_o), 0);
      check({tag, " rcon"},     32'(bus.kg_rcon_o), 0);
      check({tag, " valid"},    32'(bus.rk_valid_o), 0);
      check({tag, " idx"},      32'(bus.rk_idx_o), 0);
   endtask

   // One full expansion with ready held high except for an optional stall
   // round, plus an optional stray start pulse in the FETCH of spur_rnd.
   // Also pulses start during DONE and checks that it is lost.
   task automatic run_exp(input string tag, input int stall_rnd, input int stall_n,
                          input int spur_rnd);
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         // FETCH
         if (k == spur_rnd) bus.start_i = 1'b1;
         check($sformatf("%s r%0d fetch en", tag, k),       32'(bus.kg_en_o), 1);
         check($sformatf("%s r%0d fetch next_rnd", tag, k), 32'(bus.kg_next_rnd_o), (k > 1) ? 1 : 0);
         check($sformatf("%s r%0d fetch gen_key", tag, k),  32'(bus.kg_gen_key_o), 0);
         check($sformatf("%s r%0d fetch rcon", tag, k),     32'(bus.kg_rcon_o), 0);
         check($sformatf("%s r%0d fetch busy", tag, k),     32'(bus.busy_o), 1);
         tick();
         bus.start_i = 1'b0;
         // CALC
         check($sformatf("%s r%0d calc en", tag, k),       32'(bus.kg_en_o), 1);
         check($sformatf("%s r%0d calc gen_key", tag, k),  32'(bus.kg_gen_key_o), 1);
         check($sformatf("%s r%0d calc rcon", tag, k),     32'(bus.kg_rcon_o), 32'(vec[k-1].rcon));
         check($sformatf("%s r%0d calc next_rnd", tag, k), 32'(bus.kg_next_rnd_o), 0);
         check($sformatf("%s r%0d calc valid", tag, k),    32'(bus.rk_valid_o), 0);
         tick();
         // PRESENT
         check($sformatf("%s r%0d present valid", tag, k), 32'(bus.rk_valid_o), 1);
         check($sformatf("%s r%0d present idx", tag, k),   32'(bus.rk_idx_o), 32'(vec[k-1].idx));
         check($sformatf("%s r%0d present en", tag, k),    32'(bus.kg_en_o), 0);
         check($sformatf("%s r%0d present done", tag, k),  32'(bus.done_o), 0);
         if (k == stall_rnd) begin
            bus.rk_ready_i = 1'b0;
            for (int s = 0; s < stall_n; s++) begin
               tick();
               check($sformatf("%s stall%0d valid", tag, s), 32'(bus.rk_valid_o), 1);
               check($sformatf("%s stall%0d idx", tag, s),   32'(bus.rk_idx_o), 32'(vec[k-1].idx));
               check($sformatf("%s stall%0d en", tag, s),    32'(bus.kg_en_o), 0);
               check($sformatf("%s stall%0d busy", tag, s),  32'(bus.busy_o), 1);
            end
            bus.rk_ready_i = 1'b1;
         end
         tick();
      end
      // DONE
      check({tag, " done pulse"}, 32'(bus.done_o), 1);
      check({tag, " done busy"},  32'(bus.busy_o), 0);
      check({tag, " done valid"}, 32'(bus.rk_valid_o), 0);
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      check_idle_outputs({tag, " post-done"});
      tick();
      check({tag, " start-in-done lost"}, 32'(bus.busy_o), 0);
      $display("[TB] %s expansion complete", tag);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      for (int i = 0; i < 10; i++) vec[i].idx = 4'(i + 1);
      vec[0].rcon = 8'h01; vec[1].rcon = 8'h02; vec[2].rcon = 8'h04; vec[3].rcon = 8'h08;
      vec[4].rcon = 8'h10; vec[5].rcon = 8'h20; vec[6].rcon = 8'h40; vec[7].rcon = 8'h80;
      vec[8].rcon = 8'h1B; vec[9].rcon = 8'h36;

      rst            = 1'b1;
      bus.start_i    = 1'b0;
      bus.rk_ready_i = 1'b1;
`ifdef AES_KS_ABORT_EN
      abort_i        = 1'b0;
`endif
      tick();
      tick();
      check_idle_outputs("reset");
      rst = 1'b0;
      tick();
      check_idle_outputs("idle");
      $display("[TB] reset state checked");

      // Nominal run, also covering the rcon sequence in every CALC
      run_exp("nominal", 0, 0, 0);
      // Back-pressure of 5 cycles on round key 4
      run_exp("stall", 4, 5, 0);
      // Stray start during round 6 is ignored
      run_exp("spur", 0, 0, 6);
      // Start pulse in IDLE afterwards runs normally
      run_exp("restart", 0, 0, 0);

      // Reset in CALC of round 3 (cycle 8 after start)
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      for (int c = 1; c < 8; c++) tick();
      check("rst pre calc gen_key", 32'(bus.kg_gen_key_o), 1);
      check("rst pre calc rcon",    32'(bus.kg_rcon_o), 32'h04);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle_outputs("rst mid-op");
      tick();
      check("rst no done", 32'(bus.done_o), 0);
      $display("[TB] reset in round 3 checked");
      run_exp("after-rst", 0, 0, 0);

`ifdef AES_KS_ABORT_EN
      // Abort while round key 2 is presented (cycle 6), same-cycle transfer
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      for (int c = 1; c < 6; c++) tick();
      check("abort pre valid", 32'(bus.rk_valid_o), 1);
      check("abort pre idx",   32'(bus.rk_idx_o), 2);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      check_idle_outputs("abort");
      tick();
      check("abort no done", 32'(bus.done_o), 0);
      $display("[TB] abort in round 2 checked");
      run_exp("after-abort", 0, 0, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
